serial_sub: RTL and testbench
=============================

# serial_sub

Bit-serial two's-complement subtractor: computes `a - b` one bit per clock, LSB first, through a single full-adder cell. It pairs with the team's combinational full adders and is the area-minimal arithmetic option for the practice datapath. It uses a start/done handshake, so a bench or controller can launch one operation at a time and collect the result.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits. Legal range 2–32.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: launch request. Sampled only in IDLE.
- `a` in WIDTH: minuend. Captured on the accepted `start` edge.
- `b` in WIDTH: subtrahend. Captured on the accepted `start` edge.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse; `diff` and `borrow` are valid from this cycle onward.
- `diff` out WIDTH: `a - b` mod 2^WIDTH. Holds until the next completion.
- `borrow` out 1: 1 when unsigned `a < b`, i.e. the inverse of the final carry.
- `ovf` out 1: signed overflow. Present only with `SERIAL_SUB_OVF_EN`.

## Operation
- FSM with two states, IDLE and RUN.
- IDLE with `start`=1:
  - load `sa` ← `a`, `sb` ← `~b`
  - `carry` ← 1 (two's-complement +1)
  - `cnt` ← 0
  - go to RUN.
- IDLE with `start`=0: hold.
- RUN, each cycle:
  - The full-adder cell takes `sa[0]`, `sb[0]`, `carry` and produces sum `s` and carry out `co`.
  - `res` shifts right with `s` entering at the MSB.
  - `sa` and `sb` shift right.
  - `carry` ← `co`.
  - `cnt` increments.
- RUN with `cnt`=WIDTH-1 (last bit):
  - `diff` ← final shifted `res`
  - `borrow` ← ~`co`
  - `done` ← 1
  - return to IDLE.
- `start` during RUN is ignored; no queuing.
- `diff`, `borrow` and `ovf` change only on the completion edge; they never show partial results.
- `cnt` width is clog2(WIDTH), and it never wraps within an operation.

## Timing
- Reset values: `busy`=0, `done`=0, `diff`=0, `borrow`=0, `ovf`=0. State is IDLE and all internal registers are 0.
- `start` accepted at edge k:
  - `busy`=1 after edge k.
  - Bits are processed at edges k+1 through k+WIDTH.
  - After edge k+WIDTH: `done`=1, `busy`=0, and results are valid.
  - After edge k+WIDTH+1: `done`=0.
- Latency from the accepted `start` edge to `done` is WIDTH cycles.
- Back-to-back operation: `start` may be asserted in the cycle where `done`=1, since the FSM is in IDLE. The new operation is accepted at that edge, so throughput is one result per WIDTH+1 cycles at best.
- Reset asserted mid-operation aborts immediately. All outputs return to their reset values, no `done` pulse is produced, and the prior `diff` is lost.

## Configuration
- Macro: `SERIAL_SUB_OVF_EN`.
- Defined:
  - Port `ovf` exists.
  - On the last bit, `ovf` ← `carry` (carry into the MSB) XOR `co` (carry out of the MSB).
  - `ovf` is registered alongside `diff`, resets to 0, and holds until the next completion.
- Undefined: the `ovf` port and its register are absent. All other behaviour is identical.

## Structure
- Shared package `serial_pkg`:
  - state enum `{S_IDLE, S_RUN}`
  - `localparam` `SERIAL_MAX_WIDTH` = 32
- Sub-module `fa_cell`:
  - Purely combinational one-bit full adder with ports `a`, `b`, `ci`, `s`, `co`.
  - Equations: `s = a^b^ci`, `co = a&b | ci&(a^b)`.
  - `serial_sub` instantiates it exactly once.

## Test plan
All scenarios use WIDTH=8.
1. `a`=100, `b`=37, `start` pulse → `done` exactly 8 cycles after the start edge, `diff`=63, `borrow`=0, `busy` high for 8 cycles.
2. `a`=5, `b`=9 → `diff`=8'hFC, `borrow`=1. With `SERIAL_SUB_OVF_EN`: `ovf`=0.
3. `a`=8'h80, `b`=8'h01 → `diff`=8'h7F, `borrow`=0. With the macro: `ovf`=1. `a`=0, `b`=0 → `diff`=0, `borrow`=0, `ovf`=0.
4. Start 50−20; pulse `start` with 1−2 at cycle 3 of RUN → single `done`, `diff`=30. Second request ignored.
5. Back-to-back: assert `start` (7−3) in the `done` cycle of 50−20 → next `done` 8 cycles later with `diff`=4.
6. Deassert `rst_n` at cycle 4 of RUN → outputs 0 immediately, no `done`. After release, a fresh 10−3 gives `diff`=7.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and limits for the bit-serial arithmetic blocks.
package serial_pkg;

  localparam int SERIAL_MAX_WIDTH = 32;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } serial_state_t;

endpackage : serial_pkg

// File: rtl/serial_sub_fa_cell.sv
// One-bit combinational full adder; the only arithmetic cell in serial_sub.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule : fa_cell

// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor (a - b, LSB first, one full adder).
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  serial_state_t    state, state_next;
  logic [WIDTH-1:0] sa, sb, res, res_next;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             s, co;
  logic             last_bit;

  fa_cell u_fa (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (carry),
    .s  (s),
    .co (co)
  );

  assign last_bit = (cnt == LAST_CNT);
  assign res_next = {s, res[WIDTH-1:1]};
  assign busy     = (state == S_RUN);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start)    state_next = S_RUN;
      S_RUN:  if (last_bit) state_next = S_IDLE;
      default:              state_next = S_IDLE;
    endcase
  end

  // Operand shifters and the running sum; results are published only on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      done   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      done <= (state == S_RUN) && last_bit;
      case (state)
        S_IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= ~b;
            carry <= 1'b1;  // +1 completes the two's-complement negation of b
            cnt   <= '0;
          end
        end
        S_RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          res   <= res_next;
          carry <= co;
          if (last_bit) begin
            diff   <= res_next;
            borrow <= ~co;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= carry ^ co;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule : serial_sub

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub (WIDTH=8); checks ovf when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub;

  localparam int WIDTH  = 8;
  localparam int BUDGET = 40;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, borrow;
  logic [WIDTH-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_sub #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
  } vec_t;

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  // Drives a request at the current negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v);
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < BUDGET) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    launch(ta, tb_v);
    wait_done(lat, busy_cnt);
  endtask

  initial begin
    vec_t vecs[8];
    int   lat, bcnt, ndone;
    logic [WIDTH-1:0] seen_diff;

    vecs[0] = '{8'd100,  8'd37,   8'd63,  1'b0, 1'b0};
    vecs[1] = '{8'd5,    8'd9,    8'hFC,  1'b1, 1'b0};
    vecs[2] = '{8'h80,   8'h01,   8'h7F,  1'b0, 1'b1};
    vecs[3] = '{8'd0,    8'd0,    8'd0,   1'b0, 1'b0};
    vecs[4] = '{8'd50,   8'd20,   8'd30,  1'b0, 1'b0};
    vecs[5] = '{8'h7F,   8'hFF,   8'h80,  1'b1, 1'b1};
    vecs[6] = '{8'hFF,   8'hFF,   8'h00,  1'b0, 1'b0};
    vecs[7] = '{8'd1,    8'd2,    8'hFF,  1'b1, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("reset_busy",   busy,   0);
    check("reset_done",   done,   0);
    check("reset_diff",   diff,   0);
    check("reset_borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset_ovf",    ovf,    0);
`endif
    rst_n = 1'b1;

    // Table-driven operations: latency, busy span, results, single-cycle done.
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, lat, bcnt);
      check($sformatf("v%0d_latency", i), lat, WIDTH);
      check($sformatf("v%0d_busy_cycles", i), bcnt, WIDTH);
      check($sformatf("v%0d_done", i), done, 1);
      check($sformatf("v%0d_busy_at_done", i), busy, 0);
      check($sformatf("v%0d_diff", i), diff, vecs[i].diff);
      check($sformatf("v%0d_borrow", i), borrow, vecs[i].borrow);
`ifdef SERIAL_SUB_OVF_EN
      check($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
`endif
      @(negedge clk);
      check($sformatf("v%0d_done_drop", i), done, 0);
      check($sformatf("v%0d_diff_hold", i), diff, vecs[i].diff);
    end

    // start during RUN is ignored.
    @(negedge clk);
    launch(8'd50, 8'd20);
    repeat (2) @(negedge clk);
    a     = 8'd1;
    b     = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone     = 0;
    seen_diff = '0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        ndone++;
        seen_diff = diff;
      end
      @(negedge clk);
    end
    check("ignore_done_count", ndone, 1);
    check("ignore_diff", seen_diff, 30);
    check("ignore_idle_after", busy, 0);

    // Back-to-back: new start in the done cycle.
    run_op(8'd50, 8'd20, lat, bcnt);
    check("b2b_first_latency", lat, WIDTH);
    check("b2b_first_diff", diff, 30);
    launch(8'd7, 8'd3);
    check("b2b_busy_after_accept", busy, 1);
    wait_done(lat, bcnt);
    check("b2b_second_latency", lat, WIDTH);
    check("b2b_second_diff", diff, 4);
    check("b2b_second_borrow", borrow, 0);

    // Reset mid-operation aborts with no done pulse.
    @(negedge clk);
    launch(8'd100, 8'd37);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy",   busy,   0);
    check("abort_done",   done,   0);
    check("abort_diff",   diff,   0);
    check("abort_borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("abort_ovf",    ovf,    0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort_no_done", ndone, 0);
    check("abort_diff_lost", diff, 0);
    run_op(8'd10, 8'd3, lat, bcnt);
    check("post_reset_latency", lat, WIDTH);
    check("post_reset_diff", diff, 7);
    check("post_reset_borrow", borrow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_sub
